// File: rtl/ami_rd_arb.sv
// Round-robin read arbiter: merges NR AR requesters into one AMI read port and
// routes R beats back by the index carried in the top bits of the ID.

module ami_rd_arb_ost #(
    parameter int MAX_OST = 4,
    parameter int OCW     = $clog2(MAX_OST + 1)
) (
    input  logic           ACLK,
    input  logic           ARESET,
    input  logic           i_inc,
    input  logic           i_dec,
    output logic           o_full,
    output logic           o_nz
);
    logic [OCW-1:0] r_cnt;

    // Simultaneous grant and last beat cancel; saturating guards keep it from wrapping.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && r_cnt != OCW'(MAX_OST)) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (i_dec && !i_inc && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_full = (r_cnt >= OCW'(MAX_OST));
    assign o_nz   = (r_cnt != '0);
endmodule

module ami_rd_arb #(
    parameter int NR         = 4,
    parameter int AXI_IW     = 8,
    parameter int AXI_AW     = 32,
    parameter int AXI_LW     = 8,
    parameter int AXI_SW     = 3,
    parameter int AXI_BURSTW = 2,
    parameter int AXI_DW     = 128,
    parameter int AXI_RRESPW = 2,
    parameter int MAX_OST    = 4,
    localparam int IXW       = $clog2(NR),
    localparam int UIW       = AXI_IW - IXW,
    localparam int OCW       = $clog2(MAX_OST + 1)
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [NR*UIW-1:0]        req_arid,
    input  logic [NR*AXI_AW-1:0]     req_araddr,
    input  logic [NR*AXI_LW-1:0]     req_arlen,
    input  logic [NR*AXI_SW-1:0]     req_arsize,
    input  logic [NR*AXI_BURSTW-1:0] req_arburst,
    input  logic [NR-1:0]            req_arvalid,
    output logic [NR-1:0]            req_arready,
    output logic [UIW-1:0]           req_rid,
    output logic [AXI_DW-1:0]        req_rdata,
    output logic [AXI_RRESPW-1:0]    req_rresp,
    output logic                     req_rlast,
    output logic [NR-1:0]            req_rvalid,
    input  logic [NR-1:0]            req_rready,
    output logic [AXI_IW-1:0]        m_arid,
    output logic [AXI_AW-1:0]        m_araddr,
    output logic [AXI_LW-1:0]        m_arlen,
    output logic [AXI_SW-1:0]        m_arsize,
    output logic [AXI_BURSTW-1:0]    m_arburst,
    output logic                     m_arvalid,
    input  logic                     m_arready,
    input  logic [AXI_IW-1:0]        m_rid,
    input  logic [AXI_DW-1:0]        m_rdata,
    input  logic [AXI_RRESPW-1:0]    m_rresp,
    input  logic                     m_rlast,
    input  logic                     m_rvalid,
    output logic                     m_rready,
    output logic                     err_badid,
    output logic                     busy
);
    logic [UIW-1:0]        w_arid    [NR];
    logic [AXI_AW-1:0]     w_araddr  [NR];
    logic [AXI_LW-1:0]     w_arlen   [NR];
    logic [AXI_SW-1:0]     w_arsize  [NR];
    logic [AXI_BURSTW-1:0] w_arburst [NR];

    logic [NR-1:0]     w_full, w_nz, w_elig, w_inc, w_dec;
    logic              w_load, w_found, w_fire;
    logic [IXW-1:0]    w_gnt, w_ptr_nxt, w_idx;
    logic              w_bad;

    logic              r_arvalid;
    logic [AXI_IW-1:0] r_arid;
    logic [AXI_AW-1:0] r_araddr;
    logic [AXI_LW-1:0] r_arlen;
    logic [AXI_SW-1:0] r_arsize;
    logic [AXI_BURSTW-1:0] r_arburst;
    logic [IXW-1:0]    r_ptr;
    logic              r_err;

    assign w_load = !r_arvalid || m_arready;
    assign w_fire = w_load && w_found;

    assign w_idx = m_rid[AXI_IW-1 -: IXW];
    assign w_bad = ({1'b0, w_idx} >= (IXW+1)'(NR));

    for (genvar k = 0; k < NR; k++) begin : g_req
        assign w_arid[k]    = req_arid[k*UIW +: UIW];
        assign w_araddr[k]  = req_araddr[k*AXI_AW +: AXI_AW];
        assign w_arlen[k]   = req_arlen[k*AXI_LW +: AXI_LW];
        assign w_arsize[k]  = req_arsize[k*AXI_SW +: AXI_SW];
        assign w_arburst[k] = req_arburst[k*AXI_BURSTW +: AXI_BURSTW];

        assign w_elig[k]      = req_arvalid[k] && !w_full[k];
        assign w_inc[k]       = w_fire && (w_gnt == IXW'(k));
        assign req_arready[k] = w_inc[k] && !ARESET;
        assign req_rvalid[k]  = m_rvalid && !w_bad && (w_idx == IXW'(k));
        assign w_dec[k]       = req_rvalid[k] && m_rready && m_rlast;

        ami_rd_arb_ost #(.MAX_OST(MAX_OST), .OCW(OCW)) u_ost (
            .ACLK   (ACLK),
            .ARESET (ARESET),
            .i_inc  (w_inc[k]),
            .i_dec  (w_dec[k]),
            .o_full (w_full[k]),
            .o_nz   (w_nz[k])
        );
    end

    // First eligible requester at or above the pointer, wrapping modulo NR.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int i = 0; i < NR; i++) begin
            int c;
            c = int'(r_ptr) + i;
            if (c >= NR) c = c - NR;
            if (!w_found && w_elig[c]) begin
                w_found = 1'b1;
                w_gnt   = IXW'(c);
            end
        end
    end

    assign w_ptr_nxt = (w_gnt == IXW'(NR - 1)) ? '0 : w_gnt + 1'b1;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arvalid <= 1'b0;
            r_arid    <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            r_arvalid <= w_found;
            if (w_found) begin
                r_arid    <= {w_gnt, w_arid[w_gnt]};
                r_araddr  <= w_araddr[w_gnt];
                r_arlen   <= w_arlen[w_gnt];
                r_arsize  <= w_arsize[w_gnt];
                r_arburst <= w_arburst[w_gnt];
                r_ptr     <= w_ptr_nxt;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)                r_err <= 1'b0;
        else if (m_rvalid && w_bad) r_err <= 1'b1;
    end

    assign m_arvalid = r_arvalid;
    assign m_arid    = r_arid;
    assign m_araddr  = r_araddr;
    assign m_arlen   = r_arlen;
    assign m_arsize  = r_arsize;
    assign m_arburst = r_arburst;

    // Beats addressed to a nonexistent requester are swallowed so the port never stalls.
    assign m_rready  = w_bad ? 1'b1 : req_rready[w_idx];
    assign req_rid   = m_rid[UIW-1:0];
    assign req_rdata = m_rdata;
    assign req_rresp = m_rresp;
    assign req_rlast = m_rlast;

    assign err_badid = r_err;
    assign busy      = r_arvalid || (|w_nz);
endmodule

// File: tb/tb_ami_rd_arb.sv
// Bench for ami_rd_arb: NR=4 instance for arbitration/routing, NR=3 instance for bad-index handling.
module tb_ami_rd_arb;
    localparam int NR = 4, UIW = 6, NR3 = 3;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    logic ACLK = 0, ARESET = 0;
    always #5 ACLK = ~ACLK;

    logic [NR*UIW-1:0] req_arid;
    logic [NR*32-1:0]  req_araddr;
    logic [NR*8-1:0]   req_arlen;
    logic [NR*3-1:0]   req_arsize;
    logic [NR*2-1:0]   req_arburst;
    logic [NR-1:0]     req_arvalid = '0, req_arready, req_rvalid, req_rready = '0;
    logic [UIW-1:0]    req_rid;
    logic [127:0]      req_rdata, m_rdata = '0;
    logic [1:0]        req_rresp, m_rresp = '0, m_arburst;
    logic              req_rlast, m_arvalid, m_arready = 1, m_rlast = 0, m_rvalid = 0;
    logic              m_rready, err_badid, busy;
    logic [7:0]        m_arid, m_arlen, m_rid = '0;
    logic [31:0]       m_araddr;
    logic [2:0]        m_arsize;

    logic [NR3*UIW-1:0] r3_arid = '0;
    logic [NR3*32-1:0]  r3_araddr = '0;
    logic [NR3*8-1:0]   r3_arlen = '0;
    logic [NR3*3-1:0]   r3_arsize = '0;
    logic [NR3*2-1:0]   r3_arburst = '0;
    logic [NR3-1:0]     r3_arvalid = '0, r3_arready, r3_rvalid, r3_rready = '0;
    logic [UIW-1:0]     r3_rid;
    logic [127:0]       r3_rdata;
    logic [1:0]         r3_rresp, m3_arburst;
    logic               r3_rlast, m3_arvalid, m3_rready, err3, busy3, m3_rvalid = 0;
    logic [7:0]         m3_arid, m3_arlen, m3_rid = '0;
    logic [31:0]        m3_araddr;
    logic [2:0]         m3_arsize;

    ami_rd_arb #(.NR(NR)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_arid(req_arid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arsize(req_arsize), .req_arburst(req_arburst),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_rid(req_rid), .req_rdata(req_rdata), .req_rresp(req_rresp),
        .req_rlast(req_rlast), .req_rvalid(req_rvalid), .req_rready(req_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .err_badid(err_badid), .busy(busy)
    );

    ami_rd_arb #(.NR(NR3)) dut3 (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_arid(r3_arid), .req_araddr(r3_araddr), .req_arlen(r3_arlen),
        .req_arsize(r3_arsize), .req_arburst(r3_arburst),
        .req_arvalid(r3_arvalid), .req_arready(r3_arready),
        .req_rid(r3_rid), .req_rdata(r3_rdata), .req_rresp(r3_rresp),
        .req_rlast(r3_rlast), .req_rvalid(r3_rvalid), .req_rready(r3_rready),
        .m_arid(m3_arid), .m_araddr(m3_araddr), .m_arlen(m3_arlen), .m_arsize(m3_arsize),
        .m_arburst(m3_arburst), .m_arvalid(m3_arvalid), .m_arready(1'b1),
        .m_rid(m3_rid), .m_rdata(128'h0), .m_rresp(2'b00), .m_rlast(1'b0),
        .m_rvalid(m3_rvalid), .m_rready(m3_rready), .err_badid(err3), .busy(busy3)
    );

    int  n_vec = 0, n_err = 0;
    ar_t sb[$];
    ar_t mon_e;

    function automatic ar_t exp_ar(int k);
        ar_t e;
        logic [1:0] kk;
        kk = k[1:0];
        e.id    = {kk, 6'h10 + 6'(k)};
        e.addr  = 32'hA000_0000 + 32'(k) * 32'h100;
        e.len   = 8'(k + 1);
        e.size  = 3'd4;
        e.burst = 2'b01;
        return e;
    endfunction

    // Scoreboard: every accepted AR on the master port must match the oldest expected grant.
    always @(negedge ACLK) begin
        if (!ARESET && m_arvalid && m_arready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL ar_unexpected: got id=%h addr=%h, none expected", m_arid, m_araddr);
            end else begin
                mon_e = sb.pop_front();
                if ({m_arid, m_araddr, m_arlen, m_arsize, m_arburst} !== mon_e) begin
                    n_err++;
                    $display("FAIL ar_payload: got id=%h addr=%h len=%h, want id=%h addr=%h len=%h",
                             m_arid, m_araddr, m_arlen, mon_e.id, mon_e.addr, mon_e.len);
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK); #1;
    endtask

    task automatic do_reset();
        ARESET = 1;
        req_arvalid = '0; req_rready = '0; m_rvalid = 0; m_rlast = 0; m_rid = '0;
        r3_rready = '0; m3_rvalid = 0; m3_rid = '0; m_arready = 1;
        sb.delete();
        @(posedge ACLK); @(posedge ACLK); #1;
        ARESET = 0;
    endtask

    task automatic test_reset();
        #3 ARESET = 1; req_arvalid = 4'hF;
        #1;
        n_vec++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b want 0", m_arvalid); end
        @(negedge ACLK);
        n_vec++; if (req_arready !== 4'b0) begin n_err++; $display("FAIL rst_arready: got %b want 0000", req_arready); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (err_badid !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_badid); end
        n_vec++; if ({m_arid, m_araddr} !== 40'h0) begin n_err++; $display("FAIL rst_arfields: got %h %h want 0", m_arid, m_araddr); end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy;
        do_reset();
        req_arvalid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            exp_rdy = NR'(1) << (c % NR);
            n_vec++;
            if (req_arready !== exp_rdy) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", c, req_arready, exp_rdy); end
            sb.push_back(exp_ar(c % NR));
            tick();
        end
        req_arvalid = '0;
        @(negedge ACLK);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rr_busy: got %b want 1", busy); end
        tick();
        @(negedge ACLK);
        n_vec++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL rr_empty: got %b want 0", m_arvalid); end
    endtask

    task automatic test_ost_limit();
        do_reset();
        req_arvalid = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            n_vec++; if (req_arready !== 4'b0100) begin n_err++; $display("FAIL ost_grant%0d: got %b want 0100", c, req_arready); end
            sb.push_back(exp_ar(2));
            tick();
        end
        req_arvalid = 4'b0101;
        @(negedge ACLK);
        n_vec++; if (req_arready !== 4'b0001) begin n_err++; $display("FAIL ost_blocked_other: got %b want 0001", req_arready); end
        sb.push_back(exp_ar(0));
        tick();
        req_arvalid = 4'b0100; req_rready = 4'b0100;
        m_rvalid = 1; m_rlast = 1; m_rid = {2'd2, 6'h03};
        @(negedge ACLK);
        n_vec++; if (req_arready !== 4'b0000) begin n_err++; $display("FAIL ost_full: got %b want 0000", req_arready); end
        n_vec++; if (m_rready !== 1'b1) begin n_err++; $display("FAIL ost_rready: got %b want 1", m_rready); end
        tick();
        m_rvalid = 0; m_rlast = 0; req_rready = '0;
        @(negedge ACLK);
        n_vec++; if (req_arready !== 4'b0100) begin n_err++; $display("FAIL ost_unblock: got %b want 0100", req_arready); end
        sb.push_back(exp_ar(2));
        tick();
        req_arvalid = '0;
        tick(); tick();
    endtask

    task automatic test_stall();
        ar_t e0;
        e0 = exp_ar(0);
        do_reset();
        req_arvalid = 4'b0011;
        @(negedge ACLK);
        n_vec++; if (req_arready !== 4'b0001) begin n_err++; $display("FAIL stall_first: got %b want 0001", req_arready); end
        sb.push_back(e0);
        tick();
        m_arready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            n_vec++; if (req_arready !== 4'b0) begin n_err++; $display("FAIL stall_rdy%0d: got %b want 0000", c, req_arready); end
            n_vec++;
            if ({m_arvalid, m_arid, m_araddr} !== {1'b1, e0.id, e0.addr}) begin
                n_err++; $display("FAIL stall_hold%0d: got v=%b id=%h addr=%h want v=1 id=%h addr=%h",
                                  c, m_arvalid, m_arid, m_araddr, e0.id, e0.addr);
            end
            tick();
        end
        m_arready = 1;
        @(negedge ACLK);
        n_vec++; if (req_arready !== 4'b0010) begin n_err++; $display("FAIL stall_release: got %b want 0010", req_arready); end
        sb.push_back(exp_ar(1));
        tick();
        req_arvalid = '0;
        tick();
        @(negedge ACLK);
        n_vec++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", m_arvalid); end
    endtask

    task automatic test_r_route();
        logic [127:0] pat;
        pat = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
        do_reset();
        m_rvalid = 1; m_rid = 8'h85; m_rdata = pat; m_rresp = 2'b10; m_rlast = 0;
        req_rready = 4'b1011;
        @(negedge ACLK);
        n_vec++; if (m_rready !== 1'b0) begin n_err++; $display("FAIL route_rready_lo: got %b want 0", m_rready); end
        n_vec++; if (req_rvalid !== 4'b0100) begin n_err++; $display("FAIL route_rvalid: got %b want 0100", req_rvalid); end
        n_vec++; if (req_rid !== 6'h05) begin n_err++; $display("FAIL route_rid: got %h want 05", req_rid); end
        n_vec++; if ({req_rdata, req_rresp, req_rlast} !== {pat, 2'b10, 1'b0}) begin
            n_err++; $display("FAIL route_payload: got %h/%b/%b want %h/10/0", req_rdata, req_rresp, req_rlast, pat);
        end
        tick();
        req_rready = 4'b0100;
        @(negedge ACLK);
        n_vec++; if (m_rready !== 1'b1) begin n_err++; $display("FAIL route_rready_hi: got %b want 1", m_rready); end
        tick();
        m_rid = 8'h3A; m_rlast = 1; req_rready = 4'b0001;
        @(negedge ACLK);
        n_vec++; if ({req_rvalid, req_rid, m_rready, req_rlast} !== {4'b0001, 6'h3A, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL route_idx0: got %b %h %b %b want 0001 3a 1 1", req_rvalid, req_rid, m_rready, req_rlast);
        end
        n_vec++; if ({err_badid, busy} !== 2'b00) begin n_err++; $display("FAIL route_flags: got %b want 00", {err_badid, busy}); end
        tick();
        m_rvalid = 0; m_rlast = 0;
    endtask

    task automatic test_badid();
        do_reset();
        m3_rvalid = 1; m3_rid = 8'hC0; r3_rready = 3'b000;
        @(negedge ACLK);
        n_vec++; if (m3_rready !== 1'b1) begin n_err++; $display("FAIL bad_rready: got %b want 1", m3_rready); end
        n_vec++; if (r3_rvalid !== 3'b000) begin n_err++; $display("FAIL bad_rvalid: got %b want 000", r3_rvalid); end
        tick();
        m3_rvalid = 0; m3_rid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            n_vec++; if (err3 !== 1'b1) begin n_err++; $display("FAIL bad_sticky%0d: got %b want 1", c, err3); end
            tick();
        end
        m3_rvalid = 1; m3_rid = 8'h85; r3_rready = 3'b100;
        @(negedge ACLK);
        n_vec++; if ({r3_rvalid, m3_rready} !== {3'b100, 1'b1}) begin n_err++; $display("FAIL bad_goodidx: got %b %b want 100 1", r3_rvalid, m3_rready); end
        n_vec++; if (err_badid !== 1'b0) begin n_err++; $display("FAIL bad_nr4_clean: got %b want 0", err_badid); end
        do_reset();
        @(negedge ACLK);
        n_vec++; if (err3 !== 1'b0) begin n_err++; $display("FAIL bad_cleared: got %b want 0", err3); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_arvalid = 4'b0011;
        @(negedge ACLK); sb.push_back(exp_ar(0)); tick();
        @(negedge ACLK); sb.push_back(exp_ar(1)); tick();
        m_arready = 0; req_arvalid = 4'b1001;
        @(negedge ACLK);
        n_vec++; if ({m_arvalid, busy} !== 2'b11) begin n_err++; $display("FAIL mid_pre: got %b want 11", {m_arvalid, busy}); end
        #2 ARESET = 1;
        #1;
        n_vec++; if ({m_arvalid, busy, req_arready, m_arid, m_araddr} !== 46'h0) begin
            n_err++; $display("FAIL mid_async: got v=%b busy=%b rdy=%b id=%h addr=%h want all 0",
                              m_arvalid, busy, req_arready, m_arid, m_araddr);
        end
        sb.delete();
        @(posedge ACLK); #1;
        ARESET = 0; m_arready = 1;
        @(negedge ACLK);
        n_vec++; if (req_arready !== 4'b0001) begin n_err++; $display("FAIL mid_ptr: got %b want 0001", req_arready); end
        sb.push_back(exp_ar(0));
        tick();
        req_arvalid = '0;
        tick(); tick();
    endtask

    initial begin
        for (int k = 0; k < NR; k++) begin
            ar_t e;
            e = exp_ar(k);
            req_arid[k*UIW +: UIW] = e.id[UIW-1:0];
            req_araddr[k*32 +: 32] = e.addr;
            req_arlen[k*8 +: 8]    = e.len;
            req_arsize[k*3 +: 3]   = e.size;
            req_arburst[k*2 +: 2]  = e.burst;
        end
        test_reset();
        test_round_robin();
        test_ost_limit();
        test_stall();
        test_r_route();
        test_badid();
        test_reset_mid();
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ami_rd_arb.md
AMI_RD_ARB -- requirements
Module: ami_rd_arb

Interface
REQ-001 SHALL have parameter NR, default 4: number of read requesters (2..8).
REQ-002 SHALL have parameter AXI_IW, default 8: ID width on the master side; requester ID width UIW = AXI_IW - IXW, where IXW = $clog2(NR).
REQ-003 SHALL have parameters AXI_AW=32, AXI_LW=8, AXI_SW=3, AXI_BURSTW=2, AXI_DW=128, AXI_RRESPW=2, with the same meanings as the AMI read port fields.
REQ-004 SHALL have parameter MAX_OST, default 4: per-requester outstanding-burst limit; counter width OCW = $clog2(MAX_OST+1).
REQ-005 SHALL have a single clock and an asynchronous, active-high reset.
REQ-006 ACLK  in  1  sole clock, all logic rising-edge.
REQ-007 ARESET  in  1  asynchronous, active-high reset.
REQ-008 req_arid/araddr/arlen/arsize/arburst  in  NR*{UIW,AXI_AW,AXI_LW,AXI_SW,AXI_BURSTW}  flattened per-requester AR fields; requester k occupies slice k.
REQ-009 req_arvalid  in  NR  per-requester AR valid; req_arready  out  NR  per-requester AR ready.
REQ-010 req_rid/rdata/rresp  out  UIW/AXI_DW/AXI_RRESPW  R payload broadcast to all requesters.
REQ-011 req_rlast  out  1; req_rvalid  out  NR; req_rready  in  NR.
REQ-012 m_arid/araddr/arlen/arsize/arburst/arvalid  out, m_arready  in  AR port toward the AMI read user side.
REQ-013 m_rid/rdata/rresp/rlast/rvalid  in, m_rready  out  R port from the AMI read user side.
REQ-014 err_badid  out  1  sticky flag: response arrived with an out-of-range index.
REQ-015 busy  out  1  high while any burst is outstanding or an AR is pending.

Function
REQ-016 The AR output SHALL be one holding register; it loads when it is empty (!m_arvalid) or emptying (m_arvalid && m_arready).
REQ-017 In a load cycle, eligible requesters SHALL be those with req_arvalid[k]=1 and ost_cnt[k] < MAX_OST.
REQ-018 One eligible requester SHALL be granted by round-robin, searching from pointer ptr upward modulo NR.
REQ-019 req_arready[k] SHALL be combinational and high only for the granted k in a load cycle; all other bits are low.
REQ-020 On grant, the register SHALL capture m_arid = {k[IXW-1:0], req_arid[k]} with the other AR fields passed unchanged, and ptr SHALL become (k+1) mod NR.
REQ-021 m_arvalid SHALL follow the register: it rises the cycle after grant (latency 1) and supports one AR per cycle back-to-back.
REQ-022 If no requester is eligible in a load cycle, the register SHALL become empty (m_arvalid=0) and ptr is unchanged.
REQ-023 While m_arvalid=1 and m_arready=0, all m_ar* outputs SHALL hold stable and all req_arready bits SHALL be 0.
REQ-024 ost_cnt[k] SHALL increment on grant to k and decrement on m_rvalid && m_rready && m_rlast with idx=k.
REQ-025 When the increment and decrement for the same k fall in one cycle, ost_cnt[k] SHALL be unchanged; the counter never wraps.
REQ-026 R routing: idx = m_rid[AXI_IW-1 -: IXW].
REQ-027 req_rvalid[k] SHALL equal m_rvalid && idx==k, and req_rid SHALL equal m_rid[UIW-1:0].
REQ-028 req_rdata, req_rresp and req_rlast SHALL pass through; m_rready SHALL equal req_rready[idx]. The R path is purely combinational, 0 latency.
REQ-029 If idx >= NR, m_rready SHALL be 1 (beat dropped), no req_rvalid bit asserts, and err_badid SHALL set and hold until reset.
REQ-030 busy SHALL equal m_arvalid OR (any ost_cnt != 0).

Reset
REQ-031 On ARESET=1, regardless of clock, the block SHALL clear m_arvalid, the held AR fields, ptr, all ost_cnt and err_badid to 0.
REQ-032 During reset, req_arready SHALL be all 0.
REQ-033 Reset mid-burst SHALL discard all outstanding accounting; later R beats are routed by idx only.
REQ-034 The first grant after reset deassertion SHALL be allowed in the first clock edge with ARESET=0.

Verification
REQ-035 Scenario 1, NR=4, all four req_arvalid held high, m_arready=1: grants SHALL go 0,1,2,3,0, one per cycle, and m_arid[7:6] SHALL follow the same 0,1,2,3,0 sequence.
REQ-036 Scenario 2, requester 2 issues 4 ARs with no R returned (MAX_OST=4): the 5th AR SHALL be blocked with req_arready[2]=0 while other requesters still get grants; one RLAST beat with idx=2 SHALL unblock it the next cycle.
REQ-037 Scenario 3, m_arready=0 for 3 cycles with m_arvalid=1: m_ar* SHALL stay stable and req_arready=0; when m_arready=1, a new grant loads in that same cycle.
REQ-038 Scenario 4, R beat m_rid=8'h85 (idx 2, id 5) with req_rready[2]=0 then 1: m_rready SHALL be 0 then 1, req_rvalid=4'b0100, and req_rid=6'h05.
REQ-039 Scenario 5, NR=3, m_rid=8'hC0: m_rready=1, req_rvalid=0, and err_badid SHALL rise and stay high until ARESET.
REQ-040 Scenario 6, ARESET pulsed with 2 bursts outstanding and m_arvalid=1: all outputs SHALL be reset at once, busy=0, and the next grant SHALL start from requester 0.
